// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the bus UART.
package uart_pkg;
    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_DIVL = 2'd2;
    localparam logic [1:0] OFF_DIVH = 2'd3;

    localparam int unsigned ST_TX_BUSY   = 0;
    localparam int unsigned ST_RX_NEMPTY = 1;
    localparam int unsigned ST_RX_FULL   = 2;
    localparam int unsigned ST_RX_OVR    = 3;
    localparam int unsigned ST_FRAME_ERR = 4;
    localparam int unsigned ST_TX_DROP   = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two byte FIFO holding received characters until the CPU polls them.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bus_uart.sv
// 8N1 UART slave on the CPU valid/ready bus: DATA/STATUS/DIV registers, TX shifter, RX sampler + FIFO.
module bus_uart #(
    parameter logic [15:0] BASE      = 16'h2005,
    parameter logic [15:0] DIV_RESET = 16'd433,
    parameter int unsigned RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);
    import uart_pkg::*;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [15:0] div;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, tx_sh_nxt, rx_sh;
    logic        txd_nxt;
    logic        rx_meta, rx_sync, rx_prev;
    logic        tx_drop, frame_err, rx_ovr;
    logic        sel, acc, rd_acc, wr_acc;
    logic [1:0]  off;
    logic        tx_free, tx_start, tx_drop_set, tx_busy;
    logic        rx_stop, rx_push, rx_ovr_set, ferr_set, pop;
    logic [7:0]  fifo_dout, status;
    logic [$clog2(RX_DEPTH):0] fifo_count;
    logic        fifo_full, fifo_empty;

    assign sel    = ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} <= ({1'b0, BASE} + 17'd3));
    assign off    = 2'(addr - BASE);
    assign acc    = valid & sel & ~ready;
    assign rd_acc = acc & ~write;
    assign wr_acc = acc & write;

    // A new frame may start from IDLE or in the last cycle of STOP (zero idle bits).
    assign tx_free     = (tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == '0));
    assign tx_start    = wr_acc && (off == OFF_DATA) && tx_free;
    assign tx_drop_set = wr_acc && (off == OFF_DATA) && !tx_free;
    assign tx_busy     = (tx_state != TX_IDLE);
    assign pop         = rd_acc && (off == OFF_DATA) && !fifo_empty;

    assign status = {2'b00, tx_drop, frame_err, rx_ovr, fifo_full, ~fifo_empty, tx_busy};

    // Bus handshake, register file and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b0;
            rdata     <= 8'h00;
            div       <= DIV_RESET;
            tx_drop   <= 1'b0;
            frame_err <= 1'b0;
            rx_ovr    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            irq <= (fifo_count != '0);
            if (!valid)   ready <= 1'b0;
            else if (acc) ready <= 1'b1;
            if (rd_acc) begin
                case (off)
                    OFF_DATA: rdata <= fifo_empty ? 8'h00 : fifo_dout;
                    OFF_STAT: rdata <= status;
                    OFF_DIVL: rdata <= div[7:0];
                    default:  rdata <= div[15:8];
                endcase
            end
            if (wr_acc && (off == OFF_DIVL)) div[7:0]  <= wdata;
            if (wr_acc && (off == OFF_DIVH)) div[15:8] <= wdata;
            tx_drop   <= (tx_drop   & ~(wr_acc && (off == OFF_STAT) && wdata[ST_TX_DROP]))   | tx_drop_set;
            frame_err <= (frame_err & ~(wr_acc && (off == OFF_STAT) && wdata[ST_FRAME_ERR])) | ferr_set;
            rx_ovr    <= (rx_ovr    & ~(wr_acc && (off == OFF_STAT) && wdata[ST_RX_OVR]))    | rx_ovr_set;
        end
    end

    // TX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_start) tx_next = TX_START;
            TX_START: if (tx_cnt == '0) tx_next = TX_DATA;
            TX_DATA:  if ((tx_cnt == '0) && (tx_bit == 3'd7)) tx_next = TX_STOP;
            default:  if (tx_cnt == '0) tx_next = tx_start ? TX_START : TX_IDLE;
        endcase
    end

    // txd is computed from the next state so the pin lines up with the state register.
    always_comb begin
        tx_sh_nxt = tx_sh;
        if (tx_start)                                       tx_sh_nxt = wdata;
        else if ((tx_state == TX_DATA) && (tx_cnt == '0))   tx_sh_nxt = {1'b0, tx_sh[7:1]};
        case (tx_next)
            TX_START: txd_nxt = 1'b0;
            TX_DATA:  txd_nxt = tx_sh_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd    <= 1'b1;
            tx_sh  <= 8'h00;
            tx_cnt <= DIV_RESET;
            tx_bit <= 3'd0;
        end else begin
            txd   <= txd_nxt;
            tx_sh <= tx_sh_nxt;
            if ((tx_state == TX_IDLE) || (tx_cnt == '0)) tx_cnt <= div;
            else                                         tx_cnt <= tx_cnt - 16'd1;
            if (tx_state != TX_DATA)  tx_bit <= 3'd0;
            else if (tx_cnt == '0)    tx_bit <= tx_bit + 3'd1;
        end
    end

    // RX synchroniser, state register and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h00;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) rx_cnt <= {1'b0, div[15:1]};
            else if (rx_cnt == '0)   rx_cnt <= div;
            else                     rx_cnt <= rx_cnt - 16'd1;
            if (rx_state != RX_DATA) rx_bit <= 3'd0;
            else if (rx_cnt == '0)   rx_bit <= rx_bit + 3'd1;
            if ((rx_state == RX_DATA) && (rx_cnt == '0)) rx_sh <= {rx_sync, rx_sh[7:1]};
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (rx_cnt == '0) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if ((rx_cnt == '0) && (rx_bit == 3'd7)) rx_next = RX_STOP;
            default:  if (rx_cnt == '0) rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_stop    = (rx_state == RX_STOP) && (rx_cnt == '0);
        rx_push    = rx_stop &&  rx_sync && !fifo_full;
        rx_ovr_set = rx_stop &&  rx_sync &&  fifo_full;
        ferr_set   = rx_stop && !rx_sync;
    end

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (pop),
        .din   (rx_sh),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_bus_uart.sv
// Scoreboard bench for bus_uart: register reads, TX waveform, loopback RX, FIFO overrun, framing error, reset.
module tb_bus_uart;
    localparam logic [15:0] BASE = 16'h2005;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;
    logic        txd;
    logic        rxd;
    logic        irq;
    logic        loop;
    logic        rxd_drv;

    int n_checks = 0;
    int n_fail   = 0;
    int last_lat;
    logic last_drop;
    logic [7:0] rd_q[$];
    logic       bit_q[$];

    assign rxd = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    bus_uart #(.BASE(BASE), .DIV_RESET(16'd433), .RX_DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .write (write),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .txd   (txd),
        .rxd   (rxd),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
        int n;
        logic [7:0] e;
        rd_q.push_back(exp);
        valid = 1'b1; write = 1'b0; addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 20);
        last_lat = n;
        if (!ready) check({tag, "_ready"}, 32'(ready), 32'd1);
        e = rd_q.pop_front();
        check(tag, 32'(rdata), 32'(e));
        valid = 1'b0;
        @(negedge clk);
        last_drop = ready;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        int n;
        valid = 1'b1; write = 1'b1; addr = a; wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ready && n < 20);
        if (!ready) check("wr_ready", 32'(ready), 32'd1);
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = f[i];
            repeat (4) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (!irq && n < 300) begin @(negedge clk); n++; end
        check(tag, 32'(irq), 32'd1);
    endtask

    initial begin
        logic [9:0] frame;
        rst = 1'b1; valid = 1'b0; write = 1'b0; addr = 16'h0; wdata = 8'h00;
        loop = 1'b0; rxd_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        bus_rd(BASE + 16'd1, 8'h00, "stat_rst");
        check("ready_latency", 32'(last_lat), 32'd1);
        check("ready_drop", 32'(last_drop), 32'd0);
        bus_rd(BASE + 16'd2, 8'hB1, "divl_rst");
        bus_rd(BASE + 16'd3, 8'h01, "divh_rst");
        check("idle_txd", 32'(txd), 32'd1);

        // TX waveform of 0xA5 at 4 cycles per bit
        bus_wr(BASE + 16'd2, 8'h03);
        bus_wr(BASE + 16'd3, 8'h00);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) bit_q.push_back(frame[i]);
        valid = 1'b1; write = 1'b1; addr = BASE; wdata = 8'hA5;
        @(negedge clk);
        check("tx_ready", 32'(ready), 32'd1);
        valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 1) check("tx_bit", 32'(txd), 32'(bit_q.pop_front()));
            @(negedge clk);
        end
        check("tx_end_txd", 32'(txd), 32'd1);
        bus_rd(BASE + 16'd1, 8'h00, "stat_tx_done");

        // Drop while busy, checked through loopback
        loop = 1'b1;
        bus_wr(BASE, 8'h11);
        bus_wr(BASE, 8'h22);
        bus_rd(BASE + 16'd1, 8'h21, "stat_drop");
        wait_irq("irq_11");
        repeat (4) @(negedge clk);
        bus_wr(BASE + 16'd1, 8'h20);
        bus_rd(BASE + 16'd1, 8'h02, "stat_w1c");
        bus_rd(BASE, 8'h11, "rx_11");
        bus_rd(BASE, 8'h00, "rx_11_empty");

        // Loopback 0x3C
        bus_wr(BASE, 8'h3C);
        check("irq_pre", 32'(irq), 32'd0);
        wait_irq("irq_3c");
        bus_rd(BASE, 8'h3C, "rx_3c");
        check("irq_drop", 32'(irq), 32'd0);
        bus_rd(BASE, 8'h00, "rx_3c_empty");
        loop = 1'b0;

        // Fill FIFO and overrun
        for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
        bus_rd(BASE + 16'd1, 8'h0E, "stat_ovr");
        for (int i = 1; i <= 4; i++) bus_rd(BASE, 8'(i), "rx_fifo");
        bus_rd(BASE, 8'h00, "rx_fifo_empty");
        bus_wr(BASE + 16'd1, 8'h38);
        bus_rd(BASE + 16'd1, 8'h00, "stat_clr");

        // Framing error
        rx_frame(8'h5A, 1'b0);
        bus_rd(BASE + 16'd1, 8'h10, "stat_ferr");
        bus_rd(BASE, 8'h00, "ferr_nopush");

        // Reset mid-TX frame
        bus_wr(BASE, 8'h00);
        repeat (3) @(negedge clk);
        check("mid_txd", 32'(txd), 32'd0);
        #2 rst = 1'b1;
        #1 check("rst_async_txd", 32'(txd), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_irq", 32'(irq), 32'd0);
        bus_rd(BASE + 16'd1, 8'h00, "post_rst_stat");
        bus_rd(BASE + 16'd2, 8'hB1, "post_rst_divl");
        bus_rd(BASE + 16'd3, 8'h01, "post_rst_divh");
        check("post_rst_txd", 32'(txd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
